// File: rtl/phase_accumulator_bank.sv
// Eight-voice NCO bank: one shared adder sweeps the voices one per clock after
// each sample tick, then publishes all phases and the gate snapshot together.
module phase_accumulator_bank #(
   parameter int NUM_VOICES  = 8,
   parameter int PHASE_WIDTH = 32
) (
   input  logic                                   clk_in,
   input  logic                                   rst_in,
   input  logic                                   sample_tick_in,
   input  logic [NUM_VOICES-1:0]                  gate_in,
   input  logic                                   incr_wr_in,
   input  logic [2:0]                             incr_sel_in,
   input  logic [PHASE_WIDTH-1:0]                 incr_data_in,
   output logic [NUM_VOICES-1:0][PHASE_WIDTH-1:0] phase_out,
   output logic [NUM_VOICES-1:0]                  gate_out,
   output logic                                   phase_valid_out,
   output logic                                   busy_out,
   output logic                                   overrun_out
);

   typedef enum logic [1:0] {IDLE = 2'd0, SWEEP = 2'd1, PUBLISH = 2'd2} state_t;

   state_t                 state_reg, state_next;
   logic [2:0]             ptr_reg, ptr_next;
   logic [NUM_VOICES-1:0]  gate_snap_reg;
   logic [NUM_VOICES-1:0]  prev_gate_reg;
   logic [PHASE_WIDTH-1:0] incr_reg  [NUM_VOICES];
   logic [PHASE_WIDTH-1:0] phase_reg [NUM_VOICES];
   logic                   busy_reg, valid_reg, overrun_reg;

   logic [NUM_VOICES-1:0]  incr_we;
   logic [NUM_VOICES-1:0]  sweep_hit;
   logic                   sweep_gate;
   logic [PHASE_WIDTH-1:0] sweep_sum, sweep_phase_next;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_VOICES; gi++) begin : g_voice
         assign incr_we[gi]   = incr_wr_in && (incr_sel_in == 3'(gi));
         assign sweep_hit[gi] = (state_reg == SWEEP) && (ptr_reg == 3'(gi));
      end
   endgenerate

   always_comb begin
      state_next = state_reg;
      ptr_next   = ptr_reg;
      case (state_reg)
         IDLE: begin
            if (sample_tick_in) begin
               state_next = SWEEP;
               ptr_next   = 3'd0;
            end
         end
         SWEEP: begin
            ptr_next = ptr_reg + 3'd1;
            if (ptr_reg == 3'd7) state_next = PUBLISH;
         end
         PUBLISH: state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Shared adder; a note-on edge or a closed gate forces the phase to zero.
   always_comb begin
      sweep_gate       = gate_snap_reg[ptr_reg];
      sweep_sum        = phase_reg[ptr_reg] + incr_reg[ptr_reg];
      sweep_phase_next = (sweep_gate && prev_gate_reg[ptr_reg]) ? sweep_sum : '0;
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_reg     <= IDLE;
         ptr_reg       <= 3'd0;
         gate_snap_reg <= '0;
         gate_out      <= '0;
         busy_reg      <= 1'b0;
         valid_reg     <= 1'b0;
         overrun_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         ptr_reg   <= ptr_next;
         busy_reg  <= (state_reg != IDLE);
         valid_reg <= (state_reg == PUBLISH);
         if (state_reg == IDLE && sample_tick_in) gate_snap_reg <= gate_in;
         if (state_reg != IDLE && sample_tick_in) overrun_reg <= 1'b1;
         if (state_reg == PUBLISH) gate_out <= gate_snap_reg;
      end
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         prev_gate_reg <= '0;
         phase_out     <= '0;
         for (int i = 0; i < NUM_VOICES; i++) begin
            incr_reg[i]  <= '0;
            phase_reg[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_VOICES; i++) begin
            // A write landing on the voice being swept only affects later ticks.
            if (incr_we[i]) incr_reg[i] <= incr_data_in;
            if (sweep_hit[i]) begin
               phase_reg[i]     <= sweep_phase_next;
               prev_gate_reg[i] <= sweep_gate;
            end
            if (state_reg == PUBLISH) phase_out[i] <= phase_reg[i];
         end
      end
   end

   assign busy_out        = busy_reg;
   assign phase_valid_out = valid_reg;
   assign overrun_out     = overrun_reg;

endmodule

// File: tb/tb_phase_accumulator_bank.sv
// Directed bench for phase_accumulator_bank: sweep timing, wrap, gate edges,
// overrun, mid-sweep increment writes and asynchronous reset.
module tb_phase_accumulator_bank;
   localparam int NV = 8;
   localparam int PW = 32;

   logic                   clk_in = 1'b0;
   logic                   rst_in;
   logic                   sample_tick_in;
   logic [NV-1:0]          gate_in;
   logic                   incr_wr_in;
   logic [2:0]             incr_sel_in;
   logic [PW-1:0]          incr_data_in;
   logic [NV-1:0][PW-1:0]  phase_out;
   logic [NV-1:0]          gate_out;
   logic                   phase_valid_out;
   logic                   busy_out;
   logic                   overrun_out;

   int vectors     = 0;
   int miscompares = 0;

   phase_accumulator_bank #(.NUM_VOICES(NV), .PHASE_WIDTH(PW)) dut (
      .clk_in          (clk_in),
      .rst_in          (rst_in),
      .sample_tick_in  (sample_tick_in),
      .gate_in         (gate_in),
      .incr_wr_in      (incr_wr_in),
      .incr_sel_in     (incr_sel_in),
      .incr_data_in    (incr_data_in),
      .phase_out       (phase_out),
      .gate_out        (gate_out),
      .phase_valid_out (phase_valid_out),
      .busy_out        (busy_out),
      .overrun_out     (overrun_out)
   );

   always #5 clk_in = ~clk_in;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk_in);
      #1;
   endtask

   task automatic write_incr(input int v, input logic [31:0] d);
      incr_wr_in   = 1'b1;
      incr_sel_in  = v[2:0];
      incr_data_in = d;
      cyc();
      incr_wr_in   = 1'b0;
   endtask

   // Tick at edge T, then watch 20 cycles: busy T+1..T+9, one valid pulse at
   // T+9, phase_out frozen through T+8. Optional extra tick / increment write.
   task automatic run_tick(input int dup_at, input int wr_at, input int wr_v, input logic [31:0] wr_d);
      logic [NV-1:0][PW-1:0] pre;
      pre = phase_out;
      sample_tick_in = 1'b1;
      cyc();
      sample_tick_in = 1'b0;
      chk("busy_at_T", 32'(busy_out), 32'd0);
      chk("hold_at_T", 32'(phase_out === pre), 32'd1);
      for (int k = 1; k <= 20; k++) begin
         sample_tick_in = (k == dup_at);
         if (k == wr_at) begin
            incr_wr_in   = 1'b1;
            incr_sel_in  = wr_v[2:0];
            incr_data_in = wr_d;
         end
         cyc();
         sample_tick_in = 1'b0;
         incr_wr_in     = 1'b0;
         chk($sformatf("busy_T+%0d", k), 32'(busy_out), 32'(k <= 9));
         chk($sformatf("valid_T+%0d", k), 32'(phase_valid_out), 32'(k == 9));
         if (k <= 8) chk($sformatf("hold_T+%0d", k), 32'(phase_out === pre), 32'd1);
      end
   endtask

   initial begin
      rst_in         = 1'b1;
      sample_tick_in = 1'b0;
      gate_in        = '0;
      incr_wr_in     = 1'b0;
      incr_sel_in    = '0;
      incr_data_in   = '0;
      repeat (3) cyc();
      chk("rst_phase", 32'(phase_out === '0), 32'd1);
      chk("rst_gate", 32'(gate_out), 32'd0);
      chk("rst_valid", 32'(phase_valid_out), 32'd0);
      chk("rst_busy", 32'(busy_out), 32'd0);
      chk("rst_overrun", 32'(overrun_out), 32'd0);
      rst_in = 1'b0;
      cyc();

      // Voice 0 ramps by 0x1000_0000 after the note-on tick
      write_incr(0, 32'h1000_0000);
      gate_in = 8'h01;
      run_tick(0, 0, 0, 0);
      chk("t1_p0_a", phase_out[0], 32'h0000_0000);
      chk("t1_gate", 32'(gate_out), 32'h01);
      run_tick(0, 0, 0, 0);
      chk("t1_p0_b", phase_out[0], 32'h1000_0000);
      run_tick(0, 0, 0, 0);
      chk("t1_p0_c", phase_out[0], 32'h2000_0000);
      for (int v = 1; v < NV; v++) chk($sformatf("t1_p%0d_zero", v), phase_out[v], 32'd0);

      // Voice 3 wraps modulo 2^32; voice 0 gate closed -> 0
      write_incr(3, 32'hC000_0000);
      gate_in = 8'h08;
      run_tick(0, 0, 0, 0);
      chk("t2_p3_a", phase_out[3], 32'h0000_0000);
      chk("t2_p0_off", phase_out[0], 32'h0000_0000);
      chk("t2_gate", 32'(gate_out), 32'h08);
      run_tick(0, 0, 0, 0);
      chk("t2_p3_b", phase_out[3], 32'hC000_0000);
      run_tick(0, 0, 0, 0);
      chk("t2_p3_c", phase_out[3], 32'h8000_0000);
      run_tick(0, 0, 0, 0);
      chk("t2_p3_d", phase_out[3], 32'h4000_0000);
      chk("t2_overrun_clear", 32'(overrun_out), 32'd0);

      // Extra tick at T+4 is dropped and sets sticky overrun
      run_tick(4, 0, 0, 0);
      chk("t4_p3_wrap", phase_out[3], 32'h0000_0000);
      chk("t4_overrun", 32'(overrun_out), 32'd1);
      run_tick(0, 0, 0, 0);
      chk("t4_p3_next", phase_out[3], 32'hC000_0000);
      chk("t4_overrun_sticky", 32'(overrun_out), 32'd1);

      // Voice 5 gate 1 -> 0 -> 1 with incr 0x10
      write_incr(5, 32'h0000_0010);
      gate_in = 8'h20;
      run_tick(0, 0, 0, 0);
      chk("t5_p5_edge0", phase_out[5], 32'h0);
      run_tick(0, 0, 0, 0);
      chk("t5_p5_a", phase_out[5], 32'h10);
      chk("t5_p3_off", phase_out[3], 32'h0);
      gate_in = 8'h00;
      run_tick(0, 0, 0, 0);
      chk("t5_p5_off", phase_out[5], 32'h0);
      chk("t5_gate_off", 32'(gate_out), 32'h00);
      gate_in = 8'h20;
      run_tick(0, 0, 0, 0);
      chk("t5_p5_edge", phase_out[5], 32'h0);
      run_tick(0, 0, 0, 0);
      chk("t5_p5_b", phase_out[5], 32'h10);

      // Write to voice 2 in the cycle it is swept: old increment used
      write_incr(2, 32'h0000_0100);
      gate_in = 8'h24;
      run_tick(0, 0, 0, 0);
      chk("t6_p2_edge", phase_out[2], 32'h0);
      chk("t6_p5_cont", phase_out[5], 32'h20);
      run_tick(0, 3, 2, 32'h0000_5000);
      chk("t6_p2_old_incr", phase_out[2], 32'h0000_0100);
      run_tick(0, 0, 0, 0);
      chk("t6_p2_new_incr", phase_out[2], 32'h0000_5100);
      chk("t6_gate", 32'(gate_out), 32'h24);

      // Asynchronous reset in the middle of a sweep
      sample_tick_in = 1'b1;
      cyc();
      sample_tick_in = 1'b0;
      repeat (4) cyc();
      chk("t6r_busy_pre", 32'(busy_out), 32'd1);
      #2 rst_in = 1'b1;
      #1;
      chk("t6r_phase", 32'(phase_out === '0), 32'd1);
      chk("t6r_gate", 32'(gate_out), 32'd0);
      chk("t6r_busy", 32'(busy_out), 32'd0);
      chk("t6r_valid", 32'(phase_valid_out), 32'd0);
      chk("t6r_overrun", 32'(overrun_out), 32'd0);
      cyc();
      rst_in = 1'b0;
      for (int k = 0; k < 12; k++) begin
         cyc();
         chk($sformatf("t6r_novalid_%0d", k), 32'(phase_valid_out), 32'd0);
      end

      // Increments were cleared by reset
      gate_in = 8'h01;
      run_tick(0, 0, 0, 0);
      chk("post_rst_p0_a", phase_out[0], 32'h0);
      run_tick(0, 0, 0, 0);
      chk("post_rst_p0_b", phase_out[0], 32'h0);
      chk("post_rst_gate", 32'(gate_out), 32'h01);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end
endmodule
